// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the block-copy engine, the word RAM and the CPU side.
// Holds the default bus widths and the engine's state encoding.
package mem_copy_engine_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_DATA_WIDTH = 16;
  localparam int COUNT_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-copy initiator on one port of the falling-edge dual-port word RAM.
// Alternates READ/WRITE per word, ascending addresses, with start/busy/done handshake.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  src_address,
  input  logic [ADDR_WIDTH-1:0]  dst_address,
  input  logic [COUNT_WIDTH-1:0] length,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0]  mem_write_data,
  output logic                   mem_write_enable,
  input  logic [DATA_WIDTH-1:0]  mem_read_data
);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  src_ptr;
  logic [ADDR_WIDTH-1:0]  dst_ptr;
  logic [COUNT_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0]  data_reg;

  // Outputs are set on the edge that enters each state, so the RAM sees a
  // stable address/enable for the whole cycle including its falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      src_ptr          <= '0;
      dst_ptr          <= '0;
      count            <= '0;
      data_reg         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (length != '0) begin
              src_ptr     <= src_address;
              dst_ptr     <= dst_address;
              count       <= length;
              busy        <= 1'b1;
              mem_address <= src_address;
              state       <= READ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        READ: begin
          data_reg         <= mem_read_data;
          mem_address      <= dst_ptr;
          mem_write_enable <= 1'b1;
          state            <= WRITE;
        end

        WRITE: begin
          src_ptr          <= src_ptr + ADDR_WIDTH'(1);
          dst_ptr          <= dst_ptr + ADDR_WIDTH'(1);
          count            <= count - COUNT_WIDTH'(1);
          mem_write_enable <= 1'b0;
          if (count == COUNT_WIDTH'(1)) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            mem_address <= '0;
            state       <= DONE;
          end else begin
            mem_address <= src_ptr + ADDR_WIDTH'(1);
            state       <= READ;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy             <= 1'b0;
          done             <= 1'b0;
          mem_address      <= '0;
          mem_write_enable <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

  // Write data is only presented during WRITE; zero elsewhere.
  assign mem_write_data = mem_write_enable ? data_reg : '0;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: falling-edge RAM model, shadow-memory reference
// and per-cycle protocol expectations derived from the word/cycle schedule.
module tb_mem_copy_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_address = '0;
  logic [15:0] dst_address = '0;
  logic [15:0] length = '0;
  logic        busy, done, mem_write_enable;
  logic [15:0] mem_address, mem_write_data;
  logic [15:0] mem_read_data;

  logic [15:0] ram    [65536];
  logic [15:0] shadow [65536];
  logic        fill_req = 1'b0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0, pl_data = '0;

  int errors = 0;
  int checks = 0;

  mem_copy_engine dut (
    .clock(clock), .reset(reset), .start(start),
    .src_address(src_address), .dst_address(dst_address), .length(length),
    .busy(busy), .done(done), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] fill_val(input logic [15:0] i);
    logic [15:0] p;
    p = i * 16'h9E37;
    return p ^ 16'h1234;
  endfunction

  always @(negedge clock) begin
    if (fill_req) begin
      for (int i = 0; i < 65536; i++) ram[i] <= fill_val(16'(i));
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_write_enable) begin
      ram[mem_address] <= mem_write_data;
    end
    mem_read_data <= ram[mem_address];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_mem(input string nm);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 65536; i++)
      if (ram[i] !== shadow[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d words differ, first at %h: got %h, expected %h",
               nm, bad, first, ram[first], shadow[first]);
    end
  endtask

  // Called at posedge+1, returns at posedge+1.
  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    pl_addr = a; pl_data = v; pl_en = 1'b1;
    shadow[a] = v;
    @(negedge clock); #1 pl_en = 1'b0;
    @(posedge clock); #1;
  endtask

  // Runs one copy starting at posedge+1 and ends in the IDLE cycle after DONE
  // at posedge+1, so consecutive calls exercise the earliest restart.
  task automatic do_copy(input string nm, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input int stray_a, input int stray_b,
                         input int exp_done, input int exp_busy);
    logic [15:0] words[$];
    logic [34:0] act, exp;
    int busy_n = 0;
    int done_c = 0;
    int k;
    for (int i = 0; i < int'(l); i++) begin
      words.push_back(shadow[16'(s + i)]);
      shadow[16'(d + i)] = shadow[16'(s + i)];
    end
    src_address = s; dst_address = d; length = l; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c <= 2 * int'(l) + 2; c++) begin
      act = {busy, done, mem_write_enable, mem_address, mem_write_data};
      if (busy) busy_n++;
      if (done && done_c == 0) done_c = c;
      if (c <= 2 * int'(l)) begin
        if (c % 2 == 1) begin
          k = (c - 1) / 2;
          exp = {1'b1, 1'b0, 1'b0, 16'(s + k), 16'h0};
          act[15:0] = 16'h0;
        end else begin
          k = c / 2 - 1;
          exp = {1'b1, 1'b0, 1'b1, 16'(d + k), words[k]};
        end
      end else if (c == 2 * int'(l) + 1) begin
        exp = {1'b0, 1'b1, 1'b0, 16'h0, 16'h0};
      end else begin
        exp = '0;
      end
      check($sformatf("%s_cyc%0d", nm, c), 64'(act), 64'(exp));
      if (c == stray_a || c == stray_b) begin
        start = 1'b1;
        src_address = 16'($urandom);
        dst_address = 16'($urandom);
        length = 16'($urandom_range(1, 8));
      end else begin
        start = 1'b0;
      end
      if (c < 2 * int'(l) + 2) begin
        @(posedge clock); #1;
      end
    end
    start = 1'b0;
    check({nm, "_done_cycle"}, 64'(done_c), 64'(exp_done));
    check({nm, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
  endtask

  typedef struct {
    logic [15:0] src, dst, len;
    int stray_a, stray_b, exp_done, exp_busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] s, d, l;

    vecs[0] = '{16'h0020, 16'h0300, 16'd0, 0, 0, 1, 0};
    vecs[1] = '{16'hFFFE, 16'h0200, 16'd4, 0, 0, 9, 8};
    vecs[2] = '{16'h0030, 16'h0600, 16'd4, 3, 9, 9, 8};
    vecs[3] = '{16'h0040, 16'h0700, 16'd3, 0, 0, 7, 6};
    vecs[4] = '{16'h0800, 16'h0801, 16'd5, 0, 0, 11, 10};
    vecs[5] = '{16'h0901, 16'h0900, 16'd6, 0, 0, 13, 12};
    vecs[6] = '{16'hFFFF, 16'hFFFD, 16'd3, 0, 0, 7, 6};

    for (int i = 0; i < 65536; i++) shadow[i] = fill_val(16'(i));

    #2 reset = 1'b1;
    #1 check("reset_outputs",
             64'({busy, done, mem_write_enable, mem_address, mem_write_data}), 64'h0);
    @(posedge clock); #1 fill_req = 1'b1;
    @(negedge clock); #1 fill_req = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    check("idle_outputs",
          64'({busy, done, mem_write_enable, mem_address, mem_write_data}), 64'h0);

    poke(16'h0010, 16'h00A1);
    poke(16'h0011, 16'h00B2);
    poke(16'h0012, 16'h00C3);
    poke(16'h0013, 16'h00D4);
    do_copy("basic4", 16'h0010, 16'h0100, 16'd4, 0, 0, 9, 8);
    check("basic_w0", 64'(ram[16'h0100]), 64'h00A1);
    check("basic_w1", 64'(ram[16'h0101]), 64'h00B2);
    check("basic_w2", 64'(ram[16'h0102]), 64'h00C3);
    check("basic_w3", 64'(ram[16'h0103]), 64'h00D4);
    check_mem("basic_mem");

    // Table vectors run back to back; entry 2 carries ignored starts in
    // cycles 3 and 9 and entry 3 then starts in cycle 10.
    for (int v = 0; v < 7; v++) begin
      do_copy($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len,
              vecs[v].stray_a, vecs[v].stray_b, vecs[v].exp_done, vecs[v].exp_busy);
      check_mem($sformatf("vec%0d_mem", v));
    end
    check("wrap_w0", 64'(ram[16'h0200]), 64'(fill_val(16'hFFFE)));
    check("wrap_w1", 64'(ram[16'h0201]), 64'(fill_val(16'hFFFF)));
    check("wrap_w2", 64'(ram[16'h0202]), 64'(fill_val(16'h0000)));
    check("wrap_w3", 64'(ram[16'h0203]), 64'(fill_val(16'h0001)));

    for (int r = 0; r < 8; r++) begin
      s = 16'($urandom);
      d = 16'($urandom);
      l = 16'($urandom_range(1, 24));
      do_copy($sformatf("rnd%0d", r), s, d, l, 0, 0, 2 * int'(l) + 1, 2 * int'(l));
      check_mem($sformatf("rnd%0d_mem", r));
    end

    // Reset during the WRITE of word 1.
    s = 16'h0400; d = 16'h0500;
    src_address = s; dst_address = d; length = 16'd4; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("midreset_cyc4", 64'({mem_write_enable, mem_address}), 64'({1'b1, 16'h0501}));
    reset = 1'b1;
    #1 check("midreset_outputs",
             64'({busy, done, mem_write_enable, mem_address, mem_write_data}), 64'h0);
    @(posedge clock); #1 reset = 1'b0;
    check("midreset_w0", 64'(ram[16'h0500]), 64'(shadow[16'h0400]));
    check("midreset_w2", 64'(ram[16'h0502]), 64'(shadow[16'h0502]));
    check("midreset_w3", 64'(ram[16'h0503]), 64'(shadow[16'h0503]));
    shadow[16'h0500] = shadow[16'h0400];
    shadow[16'h0501] = ram[16'h0501];
    do_copy("after_reset", 16'h0410, 16'h0510, 16'd4, 0, 0, 9, 8);
    check_mem("after_reset_mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
